// File: rtl/rv_decode_stage.sv
// RV32I decode stage with ID/EX register, valid/ready handshake, flush and load-use interlock.
// Defining DECODE_MEXT_EN enables decode of the M extension (OP with funct7=0000001).
module rv_decode_stage #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned LOAD_USE_STALL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pcp4,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_regwrite,
    output logic [1:0]      out_memtoreg,
    output logic [1:0]      out_memrw,
    output logic [2:0]      out_branch,
    output logic [2:0]      out_alu_src,
    output logic [3:0]      out_alu_ctrl,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [31:0]     out_inst,
    output logic            out_illegal,
    output logic            out_muldiv,
    output logic            hazard_stall
);
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpAlui   = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [1:0] CntLoad  = 2'(LOAD_USE_STALL - 1);

    logic [6:0]        w_opc;
    logic [2:0]        w_f3;
    logic              w_regwrite, w_illegal, w_muldiv, w_rs1_used, w_rs2_used;
    logic [1:0]        w_memtoreg, w_memrw;
    logic [2:0]        w_branch, w_alu_src;
    logic [3:0]        w_alu_ctrl;
    logic [4:0]        w_rd;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]   w_imm, w_rs1_val, w_rs2_val;
    logic              w_hit_out, w_hit_ld, w_hazard, w_fire_in, w_fire_out;

    logic [XLEN-1:0] r_pc, r_pcp4, r_imm, r_rs1_data, r_rs2_data;
    logic [4:0]      r_rs1, r_rs2, r_rd, r_ld_rd;
    logic            r_valid, r_regwrite, r_illegal, r_muldiv;
    logic [1:0]      r_memtoreg, r_memrw, r_cnt;
    logic [2:0]      r_branch, r_alu_src, r_funct3;
    logic [3:0]      r_alu_ctrl;
    logic [6:0]      r_opcode;
    logic [31:0]     r_inst;

    assign w_opc    = in_inst[6:0];
    assign w_f3     = in_inst[14:12];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    always_comb begin
        w_regwrite = 1'b0;
        w_memtoreg = 2'b00;
        w_memrw    = 2'b00;
        w_branch   = 3'b000;
        w_alu_src  = 3'b000;
        w_alu_ctrl = 4'b0000;
        w_illegal  = 1'b0;
        w_muldiv   = 1'b0;
        w_rd       = in_inst[11:7];
        w_imm32    = '0;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        case (w_opc)
            OpLui, OpAuipc: begin
                w_regwrite = 1'b1;
                w_alu_src  = (w_opc == OpAuipc) ? 3'b100 : 3'b000;
                w_imm32    = {in_inst[31:12], 12'b0};
                w_rs1_used = 1'b0;
            end
            OpJal: begin
                w_regwrite = 1'b1;
                w_memtoreg = 2'b10;
                w_branch   = 3'b111;
                w_alu_src  = 3'b100;
                w_imm32    = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                              in_inst[30:21], 1'b0};
                w_rs1_used = 1'b0;
            end
            OpJalr: begin
                w_regwrite = 1'b1;
                w_memtoreg = 2'b10;
                w_branch   = 3'b111;
                w_alu_src  = 3'b010;
                w_alu_ctrl = 4'b0001;
                w_imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OpBranch: begin
                w_alu_src  = 3'b011;
                w_rs2_used = 1'b1;
                w_imm32    = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                              in_inst[11:8], 1'b0};
                case (w_f3)
                    3'b000:  w_branch = 3'b001;
                    3'b001:  w_branch = 3'b010;
                    3'b100:  w_branch = 3'b011;
                    3'b101:  w_branch = 3'b100;
                    3'b110:  w_branch = 3'b101;
                    3'b111:  w_branch = 3'b110;
                    default: w_illegal = 1'b1;
                endcase
            end
            OpLoad: begin
                w_regwrite = 1'b1;
                w_memtoreg = 2'b01;
                w_memrw    = 2'b10;
                w_alu_src  = 3'b010;
                w_alu_ctrl = {1'b0, w_f3};
                w_imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OpAlui: begin
                w_regwrite = 1'b1;
                w_alu_src  = 3'b010;
                // Shift-right immediates carry funct7 in the upper bits; only shamt is the operand.
                if (w_f3 == 3'b101) begin
                    w_alu_ctrl = {in_inst[30], w_f3};
                    w_imm32    = {27'b0, in_inst[24:20]};
                end else begin
                    w_alu_ctrl = {1'b0, w_f3};
                    w_imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            OpStore: begin
                w_memrw    = 2'b01;
                w_alu_src  = 3'b010;
                w_rd       = 5'd0;
                w_rs2_used = 1'b1;
                w_imm32    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OpOp: begin
                w_rs2_used = 1'b1;
                if (in_inst[31:25] == 7'b0000001) begin
`ifdef DECODE_MEXT_EN
                    w_regwrite = 1'b1;
                    w_alu_src  = 3'b011;
                    w_muldiv   = 1'b1;
                    w_alu_ctrl = {1'b1, w_f3};
`else
                    w_illegal  = 1'b1;
`endif
                end else begin
                    w_regwrite = 1'b1;
                    w_alu_src  = 3'b011;
                    w_alu_ctrl = {in_inst[30], w_f3};
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_imm = XLEN'(w_imm32);

    // Same-cycle writeback wins over the register file; x0 always reads zero.
    assign w_rs1_val = (rs1_addr == 5'd0) ? '0 :
                       (wb_en && wb_addr == rs1_addr) ? wb_data : rs1_data;
    assign w_rs2_val = (rs2_addr == 5'd0) ? '0 :
                       (wb_en && wb_addr == rs2_addr) ? wb_data : rs2_data;

    assign w_hit_out = in_valid && (r_rd != 5'd0) &&
                       ((w_rs1_used && rs1_addr == r_rd) || (w_rs2_used && rs2_addr == r_rd));
    assign w_hit_ld  = in_valid && (r_ld_rd != 5'd0) &&
                       ((w_rs1_used && rs1_addr == r_ld_rd) || (w_rs2_used && rs2_addr == r_ld_rd));
    assign w_hazard  = (r_valid && r_memrw == 2'b10 && w_hit_out) || (r_cnt != 2'd0 && w_hit_ld);

    assign in_ready     = !flush && !w_hazard && (!r_valid || out_ready);
    assign w_fire_in    = in_valid && in_ready;
    assign w_fire_out   = r_valid && out_ready;
    assign hazard_stall = w_hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;  r_pc <= '0;       r_pcp4 <= '0;     r_imm <= '0;
            r_rs1_data <= '0; r_rs2_data <= '0; r_rs1 <= '0;      r_rs2 <= '0;
            r_rd <= '0;       r_regwrite <= '0; r_memtoreg <= '0; r_memrw <= '0;
            r_branch <= '0;   r_alu_src <= '0;  r_alu_ctrl <= '0; r_opcode <= '0;
            r_funct3 <= '0;   r_inst <= '0;     r_illegal <= '0;  r_muldiv <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_fire_in) begin
            r_valid    <= 1'b1;
            r_pc       <= in_pc;
            r_pcp4     <= in_pc + XLEN'(4);
            r_imm      <= w_imm;
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
            r_rs1      <= rs1_addr;
            r_rs2      <= rs2_addr;
            r_rd       <= w_rd;
            r_regwrite <= w_regwrite;
            r_memtoreg <= w_memtoreg;
            r_memrw    <= w_memrw;
            r_branch   <= w_branch;
            r_alu_src  <= w_alu_src;
            r_alu_ctrl <= w_alu_ctrl;
            r_opcode   <= w_opc;
            r_funct3   <= w_f3;
            r_inst     <= in_inst;
            r_illegal  <= w_illegal;
            r_muldiv   <= w_muldiv;
        end else if (w_fire_out) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // A stalled entry keeps tracking writebacks so it never leaves with stale operands.
            if (wb_en && wb_addr != 5'd0 && wb_addr == r_rs1) r_rs1_data <= wb_data;
            if (wb_en && wb_addr != 5'd0 && wb_addr == r_rs2) r_rs2_data <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 2'd0;
            r_ld_rd <= 5'd0;
        end else if (flush) begin
            r_cnt <= 2'd0;
        end else if (w_fire_out && r_memrw == 2'b10 && r_rd != 5'd0) begin
            r_cnt   <= CntLoad;
            r_ld_rd <= r_rd;
        end else if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_pcp4     = r_pcp4;
    assign out_imm      = r_imm;
    assign out_rs1_data = r_rs1_data;
    assign out_rs2_data = r_rs2_data;
    assign out_rs1      = r_rs1;
    assign out_rs2      = r_rs2;
    assign out_rd       = r_rd;
    assign out_regwrite = r_regwrite;
    assign out_memtoreg = r_memtoreg;
    assign out_memrw    = r_memrw;
    assign out_branch   = r_branch;
    assign out_alu_src  = r_alu_src;
    assign out_alu_ctrl = r_alu_ctrl;
    assign out_opcode   = r_opcode;
    assign out_funct3   = r_funct3;
    assign out_inst     = r_inst;
    assign out_illegal  = r_illegal;
    assign out_muldiv   = r_muldiv;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed handshake/hazard/flush steps, then random traffic
// against an instruction-encoder-based reference model.
module tb_rv_decode_stage;
    localparam int STALL = 2;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, wb_en;
    logic [31:0] in_pc, in_inst, rs1_data, rs2_data, wb_data;
    logic [4:0]  wb_addr;

    logic        in_ready, out_valid, out_regwrite, out_illegal, out_muldiv, hazard_stall;
    logic [4:0]  rs1_addr, rs2_addr, out_rs1, out_rs2, out_rd;
    logic [31:0] out_pc, out_pcp4, out_imm, out_rs1_data, out_rs2_data, out_inst;
    logic [1:0]  out_memtoreg, out_memrw;
    logic [2:0]  out_branch, out_alu_src, out_funct3;
    logic [3:0]  out_alu_ctrl;
    logic [6:0]  out_opcode;

    logic        d1_in_ready, d1_out_valid, d1_out_regwrite, d1_out_illegal, d1_out_muldiv;
    logic        d1_hazard_stall;
    logic [4:0]  d1_rs1_addr, d1_rs2_addr, d1_out_rs1, d1_out_rs2, d1_out_rd;
    logic [31:0] d1_out_pc, d1_out_pcp4, d1_out_imm, d1_out_rs1_data, d1_out_rs2_data, d1_out_inst;
    logic [1:0]  d1_out_memtoreg, d1_out_memrw;
    logic [2:0]  d1_out_branch, d1_out_alu_src, d1_out_funct3;
    logic [3:0]  d1_out_alu_ctrl;
    logic [6:0]  d1_out_opcode;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .LOAD_USE_STALL(STALL)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_pcp4(out_pcp4), .out_imm(out_imm), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg), .out_memrw(out_memrw),
        .out_branch(out_branch), .out_alu_src(out_alu_src), .out_alu_ctrl(out_alu_ctrl),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_inst(out_inst),
        .out_illegal(out_illegal), .out_muldiv(out_muldiv), .hazard_stall(hazard_stall)
    );

    rv_decode_stage #(.XLEN(32), .LOAD_USE_STALL(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d1_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .rs1_addr(d1_rs1_addr), .rs2_addr(d1_rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(d1_out_valid), .out_ready(out_ready),
        .out_pc(d1_out_pc), .out_pcp4(d1_out_pcp4), .out_imm(d1_out_imm),
        .out_rs1_data(d1_out_rs1_data), .out_rs2_data(d1_out_rs2_data), .out_rs1(d1_out_rs1),
        .out_rs2(d1_out_rs2), .out_rd(d1_out_rd), .out_regwrite(d1_out_regwrite),
        .out_memtoreg(d1_out_memtoreg), .out_memrw(d1_out_memrw), .out_branch(d1_out_branch),
        .out_alu_src(d1_out_alu_src), .out_alu_ctrl(d1_out_alu_ctrl),
        .out_opcode(d1_out_opcode), .out_funct3(d1_out_funct3), .out_inst(d1_out_inst),
        .out_illegal(d1_out_illegal), .out_muldiv(d1_out_muldiv),
        .hazard_stall(d1_hazard_stall)
    );

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        regwrite;
        logic [1:0]  memtoreg;
        logic [1:0]  memrw;
        logic [2:0]  branch;
        logic [2:0]  alu_src;
        logic [3:0]  alu_ctrl;
        logic        illegal;
        logic        muldiv;
        logic        rs1_used;
        logic        rs2_used;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc, pcp4, rs1d, rs2d, inst;
        logic [4:0]  rs1, rs2;
        dec_t        d;
    } entry_t;

    localparam logic [31:0] LW   = 32'h0000A303;  // lw  x6,0(x1)
    localparam logic [31:0] ADD  = 32'h002303B3;  // add x7,x6,x2
    localparam logic [31:0] ADDI = 32'hFFF00293;  // addi x5,x0,-1
    localparam logic [31:0] MUL  = 32'h023100B3;  // mul x1,x2,x3

    int     n_checks = 0;
    int     n_errors = 0;
    dec_t   cur;
    entry_t m_e;
    logic   m_valid, m_have_ld;
    int     m_ld_t, t;
    logic [4:0] m_ld_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds an instruction from chosen fields/immediate value; the expected decode follows
    // from what was encoded rather than from the instruction bits.
    task automatic gen();
        int          kind = $urandom_range(0, 11);
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [4:0]  r1 = 5'($urandom_range(0, 7));
        logic [4:0]  r2 = 5'($urandom_range(0, 7));
        logic [2:0]  f3 = 3'($urandom);
        logic [31:0] rnd = $urandom;
        logic [6:0]  f7 = rnd[0] ? 7'b0100000 : 7'b0000000;
        logic [4:0]  sh = rnd[8:4];
        logic [6:0]  unk [5] = '{7'h7F, 7'h0F, 7'h73, 7'h2B, 7'h5B};
        int          v;
        logic [31:0] vb;
        cur = '0;
        cur.rs1_used = 1'b1;
        cur.rd = rd;
        case (kind)
            0, 1: begin
                vb = rnd & 32'hFFFFF000;
                in_inst = {vb[31:12], rd, (kind == 0) ? 7'b0110111 : 7'b0010111};
                cur.imm = vb; cur.regwrite = 1; cur.rs1_used = 0;
                cur.alu_src = (kind == 0) ? 3'b000 : 3'b100;
            end
            2: begin
                v = int'($urandom_range(0, 1048575)) * 2 - 1048576; vb = v;
                in_inst = {vb[20], vb[10:1], vb[11], vb[19:12], rd, 7'b1101111};
                cur.imm = vb; cur.regwrite = 1; cur.memtoreg = 2'b10; cur.branch = 3'b111;
                cur.alu_src = 3'b100; cur.rs1_used = 0;
            end
            3: begin
                v = int'($urandom_range(0, 4095)) - 2048; vb = v;
                in_inst = {vb[11:0], r1, 3'b000, rd, 7'b1100111};
                cur.imm = vb; cur.regwrite = 1; cur.memtoreg = 2'b10; cur.branch = 3'b111;
                cur.alu_src = 3'b010; cur.alu_ctrl = 4'b0001;
            end
            4: begin
                v = int'($urandom_range(0, 4095)) * 2 - 4096; vb = v;
                in_inst = {vb[12], vb[10:5], r2, r1, f3, vb[4:1], vb[11], 7'b1100011};
                cur.imm = vb; cur.alu_src = 3'b011; cur.rs2_used = 1; cur.rd = in_inst[11:7];
                case (f3)
                    3'd0: cur.branch = 3'b001;
                    3'd1: cur.branch = 3'b010;
                    3'd4: cur.branch = 3'b011;
                    3'd5: cur.branch = 3'b100;
                    3'd6: cur.branch = 3'b101;
                    3'd7: cur.branch = 3'b110;
                    default: cur.illegal = 1;
                endcase
            end
            5, 11: begin
                v = int'($urandom_range(0, 4095)) - 2048; vb = v;
                in_inst = {vb[11:0], r1, f3, rd, 7'b0000011};
                cur.imm = vb; cur.regwrite = 1; cur.memtoreg = 2'b01; cur.memrw = 2'b10;
                cur.alu_src = 3'b010; cur.alu_ctrl = {1'b0, f3};
            end
            6: begin
                cur.regwrite = 1; cur.alu_src = 3'b010;
                if (f3 == 3'd5) begin
                    in_inst = {f7, sh, r1, f3, rd, 7'b0010011};
                    cur.imm = 32'(sh); cur.alu_ctrl = {f7[5], f3};
                end else if (f3 == 3'd1) begin
                    in_inst = {7'b0, sh, r1, f3, rd, 7'b0010011};
                    cur.imm = 32'(sh); cur.alu_ctrl = {1'b0, f3};
                end else begin
                    v = int'($urandom_range(0, 4095)) - 2048; vb = v;
                    in_inst = {vb[11:0], r1, f3, rd, 7'b0010011};
                    cur.imm = vb; cur.alu_ctrl = {1'b0, f3};
                end
            end
            7: begin
                v = int'($urandom_range(0, 4095)) - 2048; vb = v;
                in_inst = {vb[11:5], r2, r1, f3, vb[4:0], 7'b0100011};
                cur.imm = vb; cur.memrw = 2'b01; cur.alu_src = 3'b010; cur.rd = 5'd0;
                cur.rs2_used = 1;
            end
            8: begin
                in_inst = {f7, r2, r1, f3, rd, 7'b0110011};
                cur.regwrite = 1; cur.alu_src = 3'b011; cur.alu_ctrl = {f7[5], f3};
                cur.rs2_used = 1;
            end
            9: begin
                in_inst = {7'b0000001, r2, r1, f3, rd, 7'b0110011};
                cur.rs2_used = 1;
`ifdef DECODE_MEXT_EN
                cur.regwrite = 1; cur.alu_src = 3'b011; cur.muldiv = 1;
                cur.alu_ctrl = {1'b1, f3};
`else
                cur.illegal = 1;
`endif
            end
            default: begin
                in_inst = {rnd[31:7], unk[$urandom_range(0, 4)]};
                cur.illegal = 1; cur.rd = in_inst[11:7];
            end
        endcase
    endtask

    function automatic logic match(input logic [4:0] r);
        return in_valid && r != 5'd0 &&
               ((cur.rs1_used && in_inst[19:15] == r) || (cur.rs2_used && in_inst[24:20] == r));
    endfunction

    function automatic logic [31:0] opval(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return rf;
    endfunction

    task automatic check_entry();
        check("pc", out_pc, m_e.pc);
        check("pcp4", out_pcp4, m_e.pcp4);
        check("imm", out_imm, m_e.d.imm);
        check("rs1_data", out_rs1_data, m_e.rs1d);
        check("rs2_data", out_rs2_data, m_e.rs2d);
        check("rs1", out_rs1, m_e.rs1);
        check("rs2", out_rs2, m_e.rs2);
        check("rd", out_rd, m_e.d.rd);
        check("regwrite", out_regwrite, m_e.d.regwrite);
        check("memtoreg", out_memtoreg, m_e.d.memtoreg);
        check("memrw", out_memrw, m_e.d.memrw);
        check("branch", out_branch, m_e.d.branch);
        check("alu_src", out_alu_src, m_e.d.alu_src);
        check("alu_ctrl", out_alu_ctrl, m_e.d.alu_ctrl);
        check("opcode", out_opcode, m_e.inst[6:0]);
        check("funct3", out_funct3, m_e.inst[14:12]);
        check("inst", out_inst, m_e.inst);
        check("illegal", out_illegal, m_e.d.illegal);
        check("muldiv", out_muldiv, m_e.d.muldiv);
    endtask

    initial begin
        logic hz, rdy, fi, fo;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0;
        in_pc = '0; in_inst = '0; rs1_data = 32'hAAAA0001; rs2_data = 32'hBBBB0002;
        wb_addr = '0; wb_data = '0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_pcp4", out_pcp4, 0);
        check("rst_out_inst", out_inst, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // addi x5,x0,-1 with nonzero rs1_data: x0 must still read zero
        @(negedge clk);
        in_valid = 1'b1; in_inst = ADDI; in_pc = 32'h100; rs1_data = 32'hDEADBEEF;
        #1 check("addi_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("addi_valid", out_valid, 1);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_alu_src", out_alu_src, 3'b010);
        check("addi_regwrite", out_regwrite, 1);
        check("addi_rd", out_rd, 5);
        check("addi_rs1_data", out_rs1_data, 0);
        check("addi_pcp4", out_pcp4, 32'h104);

        // asynchronous reset while an entry is valid
        @(negedge clk) in_valid = 1'b0; rs1_data = 32'hAAAA0001;
        #2 rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_imm", out_imm, 0);
        check("arst_regwrite", out_regwrite, 0);
        check("arst_rd", out_rd, 0);
        check("arst_pc", out_pc, 0);
        @(negedge clk) rst = 1'b1;
        #1 check("arst_in_ready", in_ready, 1);

        // load-use: u_dut (2 bubbles) and u_dut1 (1 bubble) see the same stream
        @(negedge clk) in_valid = 1'b1; in_inst = LW; out_ready = 1'b1;
        @(posedge clk); #1;
        check("lw_valid", out_valid, 1);
        check("lw_memrw", out_memrw, 2'b10);
        @(negedge clk) in_inst = ADD;
        #1;
        check("lu_hazard", hazard_stall, 1);
        check("lu_hazard1", d1_hazard_stall, 1);
        check("lu_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("lu_bubble_a", out_valid, 0);
        check("lu_bubble_a1", d1_out_valid, 0);
        @(negedge clk); #1;
        check("lu_cnt_hazard", hazard_stall, 1);
        check("lu_ready1", d1_in_ready, 1);
        @(posedge clk); #1;
        check("lu_bubble_b", out_valid, 0);
        check("lu_add_valid1", d1_out_valid, 1);
        check("lu_add_inst1", d1_out_inst, ADD);
        @(negedge clk); #1 check("lu_ready", in_ready, 1);
        @(posedge clk); #1;
        check("lu_add_valid", out_valid, 1);
        check("lu_add_inst", out_inst, ADD);
        check("lu_add_rs1", out_rs1_data, 32'hAAAA0001);

        // hold for three cycles, then writeback to x6 lands in the held operand
        @(negedge clk) out_ready = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_inst", out_inst, ADD);
            check("hold_rs1", out_rs1_data, 32'hAAAA0001);
        end
        @(negedge clk) wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h1234;
        @(posedge clk); #1;
        check("byp_rs1", out_rs1_data, 32'h1234);
        check("byp_rs2", out_rs2_data, 32'hBBBB0002);
        check("byp_inst", out_inst, ADD);
        check("byp_rd", out_rd, 7);
        check("byp_alu_src", out_alu_src, 3'b011);
        check("byp_valid", out_valid, 1);
        @(negedge clk) wb_en = 1'b0;

        // flush with a held entry and a waiting input
        @(negedge clk) flush = 1'b1; in_valid = 1'b1; in_inst = ADDI;
        #1 check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1 check("flush_valid", out_valid, 0);
        @(negedge clk) flush = 1'b0; in_inst = LW; out_ready = 1'b1;
        @(posedge clk); #1 check("fl_lw_valid", out_valid, 1);
        // flush in the same cycle the load leaves must not arm the load-use counter
        @(negedge clk) in_inst = ADD; flush = 1'b1;
        @(posedge clk);
        @(negedge clk) flush = 1'b0;
        #1;
        check("fl_cnt_ready", in_ready, 1);
        check("fl_cnt_hazard", hazard_stall, 0);
        @(posedge clk); #1 check("fl_add_inst", out_inst, ADD);

        // illegal opcode and M-extension encoding
        @(negedge clk) in_inst = 32'h0000007F;
        @(posedge clk); #1;
        check("ill_valid", out_valid, 1);
        check("ill_flag", out_illegal, 1);
        check("ill_ctrl", {out_regwrite, out_memtoreg, out_memrw, out_branch, out_alu_src,
                           out_alu_ctrl, out_muldiv}, 0);
        @(negedge clk) in_inst = MUL;
        @(posedge clk); #1;
`ifdef DECODE_MEXT_EN
        check("mul_muldiv", out_muldiv, 1);
        check("mul_illegal", out_illegal, 0);
        check("mul_alu_ctrl", out_alu_ctrl, 4'b1000);
        check("mul_regwrite", out_regwrite, 1);
`else
        check("mul_muldiv", out_muldiv, 0);
        check("mul_illegal", out_illegal, 1);
        check("mul_alu_ctrl", out_alu_ctrl, 4'b0000);
        check("mul_regwrite", out_regwrite, 0);
`endif

        // random traffic against the reference model
        @(negedge clk) rst = 1'b0; in_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        m_valid = 1'b0; m_have_ld = 1'b0; m_ld_t = 0; m_ld_rd = '0; t = 0; m_e = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            gen();
            in_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & ~32'd3);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            #1;
            hz  = (m_valid && m_e.d.memrw == 2'b10 && match(m_e.d.rd)) ||
                  (m_have_ld && t < m_ld_t + STALL && match(m_ld_rd));
            rdy = !flush && !hz && (!m_valid || out_ready);
            check("in_ready", in_ready, rdy);
            check("hazard", hazard_stall, hz);
            check("rs1_addr", rs1_addr, in_inst[19:15]);
            check("rs2_addr", rs2_addr, in_inst[24:20]);
            fi = in_valid && rdy;
            fo = m_valid && out_ready;
            if (flush) begin
                m_valid   = 1'b0;
                m_have_ld = 1'b0;
            end else begin
                if (fo && m_e.d.memrw == 2'b10 && m_e.d.rd != 5'd0) begin
                    m_have_ld = 1'b1; m_ld_t = t; m_ld_rd = m_e.d.rd;
                end
                if (fi) begin
                    m_valid   = 1'b1;
                    m_e.pc    = in_pc;
                    m_e.pcp4  = in_pc + 32'd4;
                    m_e.inst  = in_inst;
                    m_e.rs1   = in_inst[19:15];
                    m_e.rs2   = in_inst[24:20];
                    m_e.rs1d  = opval(in_inst[19:15], rs1_data);
                    m_e.rs2d  = opval(in_inst[24:20], rs2_data);
                    m_e.d     = cur;
                end else if (fo) begin
                    m_valid = 1'b0;
                end else if (m_valid && wb_en && wb_addr != 5'd0) begin
                    if (wb_addr == m_e.rs1) m_e.rs1d = wb_data;
                    if (wb_addr == m_e.rs2) m_e.rs2d = wb_data;
                end
            end
            t++;
            @(posedge clk); #1;
            check("out_valid", out_valid, m_valid);
            if (m_valid) check_entry();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Parametrised RV32I decode stage with ID/EX output register; successor to the keep/nop-driven decode stage.
- Replaces keep/nop with valid/ready handshake and flush, and detects load-use hazards internally with a configurable bubble count.
- Bypasses same-cycle register-file writeback into both the captured and the held operands, and flags illegal opcodes.
- Sits between the IF/ID register and the execute stage.

Parameters:
XLEN, 32, datapath width; immediates sign-/zero-extended to XLEN.
LOAD_USE_STALL, 1, bubbles inserted between a load and a dependent instruction; legal range 1..3.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of held entry and hazard state
in_valid  in  1  IF/ID entry valid
in_ready  out  1  stage accepts entry this cycle
in_pc  in  XLEN  instruction PC
in_inst  in  32  instruction word
rs1_addr  out  5  regfile read index, = in_inst[19:15], combinational
rs2_addr  out  5  regfile read index, = in_inst[24:20], combinational
rs1_data  in  XLEN  regfile read data 1
rs2_data  in  XLEN  regfile read data 2
wb_en  in  1  writeback write enable
wb_addr  in  5  writeback index
wb_data  in  XLEN  writeback data
out_valid  out  1  output entry valid
out_ready  in  1  execute accepts entry
out_pc, out_pcp4  out  XLEN  PC and PC+4 (modulo 2^XLEN)
out_imm  out  XLEN  decoded immediate
out_rs1_data, out_rs2_data  out  XLEN  operands
out_rs1, out_rs2, out_rd  out  5  register indices
out_regwrite  out  1  writes rd
out_memtoreg  out  2  00 ALU, 01 memory, 10 PC+4
out_memrw  out  2  00 none, 10 load, 01 store
out_branch  out  3  000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu, 111 jal/jalr
out_alu_src  out  3  000 imm only (lui), 100 pc+imm, 010 rs1+imm, 011 rs1+rs2
out_alu_ctrl  out  4  ALU op
out_opcode  out  7  opcode
out_funct3  out  3  funct3
out_inst  out  32  instruction word
out_illegal  out  1  unknown opcode
out_muldiv  out  1  M-extension op
hazard_stall  out  1  load-use block active this cycle

Behaviour:
- Reset (rst=0, async): every output register clears to 0, including out_valid; hazard counter and ld_rd clear to 0.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- fire_in = in_valid && in_ready; fire_out = out_valid && out_ready.
- Capture: on fire_in the output register loads the decoded entry next edge and out_valid=1. Latency 1 cycle.
- If fire_out and no fire_in: out_valid<=0 and all other output fields hold their values.
- If out_valid && !out_ready: all fields hold, except operand bypass (below).
- Flush has priority over capture: out_valid<=0, counter<=0; fields are don't-care and hold.
- Operand capture: rsN_data is replaced by wb_data when wb_en && wb_addr==rsN_addr && wb_addr!=0. Index x0 always yields 0.
- Held bypass: while an entry is held, if wb_en && wb_addr==out_rsN && wb_addr!=0, out_rsN_data<=wb_data.
- Source use:
  - rs1 used by all opcodes except LUI, AUIPC, JAL.
  - rs2 used by BRANCH, STORE, OP.
- match(r): in_valid && r!=0 && ((rs1 used && rs1_addr==r) || (rs2 used && rs2_addr==r)).
- hazard = (out_valid && out_memrw==10 && match(out_rd)) || (cnt!=0 && match(ld_rd)).
- Counter: on fire_out of a load with out_rd!=0: cnt<=LOAD_USE_STALL-1, ld_rd<=out_rd. Otherwise cnt decrements while nonzero (floor at 0).
- A load followed by a dependent instruction therefore yields exactly LOAD_USE_STALL empty out_valid cycles.
- hazard_stall = hazard.
- Decode per opcode:
  - LUI: regwrite=1, alu_src=000.
  - AUIPC: regwrite=1, alu_src=100.
  - JAL: regwrite=1, memtoreg=10, branch=111, alu_src=100, alu_ctrl=0000.
  - JALR: regwrite=1, memtoreg=10, branch=111, alu_src=010, alu_ctrl=0001.
  - LOAD: regwrite=1, memtoreg=01, memrw=10, alu_src=010, alu_ctrl={0,f3}.
  - ALUI: regwrite=1, alu_src=010, alu_ctrl = f3==101 ? {inst[30],f3} : {0,f3}.
  - BRANCH: branch from f3 per encoding; reserved f3 (010, 011) gives branch=000 and illegal=1; alu_src=011.
  - STORE: memrw=01, alu_src=010, out_rd=0.
  - OP: regwrite=1, alu_src=011, alu_ctrl={inst[30],f3}.
- Immediates: standard I/S/B/U/J forms, sign-extended to XLEN; SRLI/SRAI shamt zero-extended.
- Unknown opcode: all control fields 0, out_illegal=1, entry still valid.

Optional Feature:
DECODE_MEXT_EN:
- Defined: OP with funct7=0000001 decodes as regwrite=1, alu_src=011, out_muldiv=1, alu_ctrl={1,f3}.
- Undefined: out_muldiv is tied 0, and that encoding is treated as an unknown opcode (illegal=1, controls 0).

Test Plan:
- Reset mid-stream with out_valid=1 -> all outputs 0 asynchronously; in_ready=1 after release.
- addi x5,x0,-1 (0xFFF00293) accepted -> next cycle out_imm=0xFFFFFFFF, alu_src=010, regwrite=1, out_rd=5.
- lw x6,0(x1) then add x7,x6,x2, LOUD_USE_STALL=1 -> one bubble cycle; add issues 2 cycles after lw leaves. Repeat with 2 -> two bubbles.
- out_ready=0 for 3 cycles holding add x7,x6,x2, then wb_en to x6 with 0x1234 -> out_rs1_data=0x1234; all other fields unchanged.
- flush with in_valid=1 and entry held -> out_valid=0 next cycle, in_ready=0 during flush, counter cleared.
- Opcode 0x0000007F -> out_illegal=1, controls 0; mul x1,x2,x3 (0x023100B3) -> out_muldiv=1 if DECODE_MEXT_EN, else illegal=1.
